// File: rtl/secded_pkg.sv
// Shared helpers for the SEC-DED decoder: check-bit count, codeword layout,
// classification enum and a reference encoder for the write side.
package secded_pkg;

   localparam int MAX_DW = 64;
   localparam int MAX_CW = 128;

   typedef enum logic [1:0] {
      CLEAN = 2'd0,
      SEC   = 2'd1,
      DED   = 2'd2
   } cls_e;

   // Smallest P with 2^P >= data_w + P + 1.
   function automatic int calc_p(input int data_w);
      int p;
      p = 1;
      for (int k = 20; k >= 1; k--)
         if ((1 << k) >= data_w + k + 1) p = k;
      return p;
   endfunction

   function automatic bit is_pow2(input int pos);
      return (pos != 0) && ((pos & (pos - 1)) == 0);
   endfunction

   // Hamming position of data bit i: the i-th non-power-of-two position >= 3.
   function automatic int data_pos(input int i);
      int n, r;
      n = 0;
      r = 0;
      for (int pos = 3; pos < MAX_CW; pos++)
         if (!is_pow2(pos)) begin
            if (n == i) r = pos;
            n++;
         end
      return r;
   endfunction

   // Positions 1..n that have bit k of their index set (coverage of check bit k).
   function automatic logic [MAX_CW-1:0] cover_mask(input int k, input int n);
      logic [MAX_CW-1:0] m;
      m = '0;
      for (int i = 1; i < MAX_CW; i++)
         if (i <= n && ((i >> k) & 1) == 1) m[i] = 1'b1;
      return m;
   endfunction

   // Extended-Hamming encoder: data into non-pow2 slots, check bits at 2^k,
   // overall parity in bit 0.
   function automatic logic [MAX_CW-1:0] encode(input logic [MAX_DW-1:0] data,
                                                input int               data_w);
      logic [MAX_CW-1:0] cw;
      int n, s;
      cw = '0;
      s  = 0;
      n  = data_w + calc_p(data_w);
      for (int i = 0; i < MAX_DW; i++)
         if (i < data_w && data[i]) begin
            cw[data_pos(i)] = 1'b1;
            s = s ^ data_pos(i);
         end
      for (int k = 0; k < 8; k++)
         if ((1 << k) <= n) cw[1 << k] = s[k];
      cw[0] = ^cw;
      return cw;
   endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of a codeword.
module secded_syndrome
   import secded_pkg::*;
#(
   parameter int N = 12,
   parameter int P = 4
) (
   input  logic [N:0]   cw,
   output logic [P-1:0] syn,
   output logic         par
);

   // Syndrome bit k is the parity over every position whose index has bit k set.
   for (genvar k = 0; k < P; k++) begin : g_syn
      localparam logic [MAX_CW-1:0] MASK = cover_mask(k, N);
      assign syn[k] = ^(cw & MASK[N:0]);
   end

   assign par = ^cw;

endmodule

// File: rtl/secded_pipe_decoder.sv
// Two-stage SEC-DED decoder with valid/ready flow control and saturating
// single/double error counters.
module secded_pipe_decoder
   import secded_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int CNT_W  = 16,
   localparam int P      = calc_p(DATA_W),
   localparam int CW_W   = DATA_W + P + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_cw,
   input  logic              in_corr_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sec,
   output logic              out_ded,
   output logic [P-1:0]      out_syndrome,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  sec_count,
   output logic [CNT_W-1:0]  ded_count
);

   localparam int N = CW_W - 1;

   logic [2:1]        vld_pipe_q, vld_pipe_d;
   logic [CW_W-1:0]   cw1_q, cw1_d;
   logic              corr1_q, corr1_d;
   logic [P-1:0]      syn1_q, syn1_d;
   logic              par1_q, par1_d;
   logic [DATA_W-1:0] data2_q, data2_d;
   logic              sec2_q, sec2_d;
   logic              ded2_q, ded2_d;
   logic [P-1:0]      syn2_q, syn2_d;
   logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
   logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;

   logic              adv1, adv2;
   logic [P-1:0]      syn_in;
   logic              par_in;
   cls_e              cls;
   logic [CW_W-1:0]   cw_fix;
   logic [DATA_W-1:0] data_fix;
   logic              out_hs;

   // A stage advances when it is empty or its successor advances; no bubbles.
   assign adv2     = !vld_pipe_q[2] || out_ready;
   assign adv1     = !vld_pipe_q[1] || adv2;
   assign in_ready = adv1;
   assign out_hs   = vld_pipe_q[2] && out_ready;

   secded_syndrome #(.N(N), .P(P)) u_syn (
      .cw  (in_cw),
      .syn (syn_in),
      .par (par_in)
   );

   // Classify the stage-1 word from its latched syndrome and parity.
   always_comb begin
      cls = CLEAN;
      if (par1_q)
         cls = (32'(syn1_q) <= N) ? SEC : DED;
      else if (syn1_q != '0)
         cls = DED;
   end

   // Flip the erroneous position on a correctable error; syndrome 0 hits cw[0] only.
   always_comb begin
      cw_fix = cw1_q;
      if (cls == SEC && corr1_q)
         cw_fix = cw1_q ^ (CW_W'(1) << syn1_q);
   end

   for (genvar i = 0; i < DATA_W; i++) begin : g_ext
      assign data_fix[i] = cw_fix[data_pos(i)];
   end

   // Pipeline next state: load each stage only when it advances.
   always_comb begin
      vld_pipe_d = vld_pipe_q;
      cw1_d      = cw1_q;
      corr1_d    = corr1_q;
      syn1_d     = syn1_q;
      par1_d     = par1_q;
      data2_d    = data2_q;
      sec2_d     = sec2_q;
      ded2_d     = ded2_q;
      syn2_d     = syn2_q;
      if (adv1) begin
         vld_pipe_d[1] = in_valid;
         if (in_valid) begin
            cw1_d   = in_cw;
            corr1_d = in_corr_en;
            syn1_d  = syn_in;
            par1_d  = par_in;
         end
      end
      if (adv2) begin
         vld_pipe_d[2] = vld_pipe_q[1];
         if (vld_pipe_q[1]) begin
            data2_d = data_fix;
            sec2_d  = (cls == SEC);
            ded2_d  = (cls == DED);
            syn2_d  = syn1_q;
         end
      end
   end

   // Error counters: count delivered words, saturate, clear wins over increment.
   always_comb begin
      sec_cnt_d = sec_cnt_q;
      ded_cnt_d = ded_cnt_q;
      if (clr_cnt) begin
         sec_cnt_d = '0;
         ded_cnt_d = '0;
      end else begin
         if (out_hs && sec2_q && sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + CNT_W'(1);
         if (out_hs && ded2_q && ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + CNT_W'(1);
      end
   end

   // State registers; reset drops any in-flight words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe_q <= '0;
         cw1_q      <= '0;
         corr1_q    <= 1'b0;
         syn1_q     <= '0;
         par1_q     <= 1'b0;
         data2_q    <= '0;
         sec2_q     <= 1'b0;
         ded2_q     <= 1'b0;
         syn2_q     <= '0;
         sec_cnt_q  <= '0;
         ded_cnt_q  <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         cw1_q      <= cw1_d;
         corr1_q    <= corr1_d;
         syn1_q     <= syn1_d;
         par1_q     <= par1_d;
         data2_q    <= data2_d;
         sec2_q     <= sec2_d;
         ded2_q     <= ded2_d;
         syn2_q     <= syn2_d;
         sec_cnt_q  <= sec_cnt_d;
         ded_cnt_q  <= ded_cnt_d;
      end
   end

   assign out_valid    = vld_pipe_q[2];
   assign out_data     = data2_q;
   assign out_sec      = sec2_q;
   assign out_ded      = ded2_q;
   assign out_syndrome = syn2_q;
   assign sec_count    = sec_cnt_q;
   assign ded_count    = ded_cnt_q;

endmodule

// File: tb/tb_secded_pipe_decoder.sv
// Scoreboard bench for secded_pipe_decoder (DATA_W=8, CNT_W=2).
module tb_secded_pipe_decoder;
   import secded_pkg::*;

   localparam int DW   = 8;
   localparam int CW   = 13;
   localparam int CNTW = 2;
   localparam int CMAX = 3;
   localparam int DPOS [DW] = '{3, 5, 6, 7, 9, 10, 11, 12};

   logic            clk = 1'b0, rst_n = 1'b1;
   logic            in_valid = 1'b0, in_corr_en = 1'b0, in_ready;
   logic [CW-1:0]   in_cw = '0;
   logic            out_valid, out_ready = 1'b1, out_sec, out_ded;
   logic [DW-1:0]   out_data;
   logic [3:0]      out_syndrome;
   logic            clr_cnt = 1'b0;
   logic [CNTW-1:0] sec_count, ded_count;

   always #5 clk = ~clk;

   secded_pipe_decoder #(.DATA_W(DW), .CNT_W(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_cw(in_cw), .in_corr_en(in_corr_en), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sec(out_sec),
      .out_ded(out_ded), .out_syndrome(out_syndrome), .clr_cnt(clr_cnt),
      .sec_count(sec_count), .ded_count(ded_count)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sec;
      logic          ded;
      logic [3:0]    syn;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, failures = 0;
   bit   rnd_rdy = 0, rnd_clr = 0;
   int   m_sec = 0, m_ded = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [DW-1:0] d, input logic s, input logic dd,
                               input logic [3:0] sy);
      exp_t e;
      e.data = d; e.sec = s; e.ded = dd; e.syn = sy;
      return e;
   endfunction

   function automatic logic [CW-1:0] tb_encode(input logic [DW-1:0] d);
      logic [CW-1:0] cw;
      int s;
      cw = '0;
      s  = 0;
      for (int i = 0; i < DW; i++)
         if (d[i]) begin cw[DPOS[i]] = 1'b1; s = s ^ DPOS[i]; end
      for (int k = 0; k < 4; k++) cw[1 << k] = s[k];
      cw[0] = ^cw[CW-1:1];
      return cw;
   endfunction

   function automatic logic [DW-1:0] extract(input logic [CW-1:0] cw);
      logic [DW-1:0] d;
      for (int i = 0; i < DW; i++) d[i] = cw[DPOS[i]];
      return d;
   endfunction

   // Build a codeword with nerr distinct flipped bits and predict the decode.
   // The syndrome of a corrupted word is the XOR of the flipped positions.
   task automatic make_word(input logic [DW-1:0] d, input logic corr, input int nerr,
                            output logic [CW-1:0] cw_o, output exp_t e);
      logic [CW-1:0] cw, c2;
      int pos[3];
      int s;
      bit dup;
      cw = tb_encode(d);
      s  = 0;
      for (int j = 0; j < nerr; j++) begin
         do begin
            pos[j] = int'($urandom_range(0, CW - 1));
            dup = 0;
            for (int m = 0; m < j; m++) if (pos[m] == pos[j]) dup = 1;
         end while (dup);
         cw[pos[j]] = ~cw[pos[j]];
         s = s ^ pos[j];
      end
      e = mk(extract(cw), 1'b0, 1'b0, s[3:0]);
      if (nerr % 2 == 1) begin
         if (s <= CW - 1) begin
            e.sec = 1'b1;
            if (corr) begin c2 = cw; c2[s] = ~c2[s]; e.data = extract(c2); end
         end else e.ded = 1'b1;
      end else if (nerr != 0) e.ded = 1'b1;
      cw_o = cw;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      if (rnd_clr) clr_cnt = ($urandom_range(0, 31) == 0);
   endtask

   task automatic send(input logic [CW-1:0] cw, input logic corr, input exp_t e);
      int n;
      n = 0;
      in_valid = 1'b1; in_cw = cw; in_corr_en = corr;
      forever begin
         @(negedge clk);
         if (in_ready) begin exp_q.push_back(e); tick(); break; end
         tick();
         n++;
         if (n > 500) begin
            $display("FAIL send_timeout: in_ready stuck low");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
            $fatal(1, "send timeout");
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      in_valid = 1'b0;
      while (exp_q.size() > 0 && n < 200) begin tick(); n++; end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // Monitor: counters every cycle, output stability under stall, scoreboard pop.
   exp_t hold;
   bit   hold_v = 0;
   always @(negedge clk) begin
      exp_t a, e;
      bit hs_sec, hs_ded;
      hs_sec = 0; hs_ded = 0;
      if (!rst_n) begin
         hold_v = 0; m_sec = 0; m_ded = 0;
      end else begin
         chk("sec_count", sec_count, m_sec);
         chk("ded_count", ded_count, m_ded);
         a = mk(out_data, out_sec, out_ded, out_syndrome);
         if (hold_v) chk("stall_stable", {out_valid, a}, {1'b1, hold});
         hold_v = 0;
         if (out_valid) begin
            chk("sec_ded_excl", out_sec && out_ded, 0);
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_output: got data 0x%0h with empty scoreboard", out_data);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", out_data, e.data);
                  chk("out_sec", out_sec, e.sec);
                  chk("out_ded", out_ded, e.ded);
                  chk("out_syndrome", out_syndrome, e.syn);
                  hs_sec = e.sec; hs_ded = e.ded;
               end
            end else begin
               hold = a; hold_v = 1;
            end
         end
         if (clr_cnt) begin m_sec = 0; m_ded = 0; end
         else begin
            if (hs_sec && m_sec < CMAX) m_sec++;
            if (hs_ded && m_ded < CMAX) m_ded++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [MAX_CW-1:0] full;
      logic [CW-1:0]     cw, wcw[4];
      exp_t              e, we[4];
      int                acc, n;

      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_syndrome", out_syndrome, 0);
      chk("rst_flags", {out_sec, out_ded}, 0);
      rst_n = 1'b1;
      tick();

      full = encode(64'hA5, DW);
      chk("pkg_encode", full[CW-1:0], 13'h144E);
      chk("tb_encode", tb_encode(8'hA5), 13'h144E);

      // clean word and its latency
      send(13'h144E, 1'b1, mk(8'hA5, 0, 0, 0));
      in_valid = 1'b0;
      @(negedge clk); chk("latency_c1", out_valid, 0);
      @(negedge clk); chk("latency_c2", out_valid, 1);
      tick();

      // directed error cases
      send(13'h140E, 1'b1, mk(8'hA5, 1, 0, 6));
      send(13'h140E, 1'b0, mk(8'hA1, 1, 0, 6));
      send(13'h100E, 1'b1, mk(8'h81, 0, 1, 12));
      send(13'h144F, 1'b1, mk(8'hA5, 1, 0, 0));
      drain();
      chk("sec_after_directed", sec_count, 3);
      chk("ded_after_directed", ded_count, 1);

      // saturation after clear
      clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
      for (int j = 0; j < 5; j++) begin
         make_word(8'($urandom), 1'b1, 1, cw, e);
         send(cw, 1'b1, e);
      end
      drain();
      chk("sec_saturated", sec_count, 3);

      // clear in the same cycle as a sec handshake
      out_ready = 1'b0;
      send(13'h140E, 1'b1, mk(8'hA5, 1, 0, 6));
      in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("clr_wait_valid", out_valid, 1);
      tick();
      out_ready = 1'b1; clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      chk("clr_priority", sec_count, 0);

      // backpressure: 3 stalled cycles accept exactly 2 words
      for (int j = 0; j < 4; j++) make_word(8'($urandom), 1'b1, 1, wcw[j], we[j]);
      out_ready = 1'b0;
      in_valid = 1'b1; in_corr_en = 1'b1;
      acc = 0;
      for (int c = 0; c < 3; c++) begin
         in_cw = wcw[acc];
         @(negedge clk);
         if (in_ready) begin exp_q.push_back(we[acc]); acc++; end
         tick();
      end
      chk("bp_accepted", acc, 2);
      chk("bp_in_ready_low", in_ready, 0);
      out_ready = 1'b1;
      for (int j = acc; j < 4; j++) send(wcw[j], 1'b1, we[j]);
      drain();

      // reset with both stages full
      out_ready = 1'b0;
      make_word(8'h3C, 1'b1, 1, cw, e); send(cw, 1'b1, e);
      make_word(8'hC3, 1'b1, 2, cw, e); send(cw, 1'b1, e);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_counts", {sec_count, ded_count}, 0);
      exp_q.delete();
      #5 rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      send(13'h144E, 1'b1, mk(8'hA5, 0, 0, 0));
      drain();

      // randomized traffic with random backpressure and clears
      rnd_rdy = 1; rnd_clr = 1;
      for (int j = 0; j < 400; j++) begin
         logic corr;
         corr = 1'($urandom);
         make_word(8'($urandom), corr, int'($urandom_range(0, 3)), cw, e);
         send(cw, corr, e);
      end
      in_valid = 1'b0;
      rnd_rdy = 0; rnd_clr = 0;
      out_ready = 1'b1; clr_cnt = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
